// File: rtl/uart_cfg_sequencer.sv
// Sequencer that reprograms the UART config regfile in a safe order: disable, wait idle, BAUD, commit, clear error, CTRL.
// Optional CTRL readback state is compiled in with `define UART_CFG_SEQ_VERIFY_EN.
module uart_cfg_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int AW             = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_enable,
    input  logic [2:0]            cfg_mode,
    input  logic [15:0]           cfg_rate,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic [1:0]            cfg_status,
    output logic                  rf_wr_en,
    output logic [AW-1:0]         rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic [AW-1:0]         rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_BAUD   = AW'(1);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(2);
    // Out-of-range address parked on the port so the regfile write bypass never aliases a poll read.
    localparam logic [AW-1:0] ADDR_PARK   = '1;

    localparam logic [1:0] RES_OK          = 2'd0;
    localparam logic [1:0] RES_BUSY_TO     = 2'd1;
    localparam logic [1:0] RES_COMMIT_TO   = 2'd2;
`ifdef UART_CFG_SEQ_VERIFY_EN
    localparam logic [1:0] RES_CTRL_MISMATCH = 2'd3;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DIS,
        ST_WAIT_IDLE,
        ST_WR_BAUD,
        ST_WAIT_COMMIT,
        ST_CLR_ERR,
        ST_WR_CTRL,
`ifdef UART_CFG_SEQ_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE,
        ST_FAIL
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    req_enable_q;
    logic [2:0]              req_mode_q;
    logic [15:0]             req_rate_q;
    logic                    cfg_ready_q;
    logic                    cfg_done_q;
    logic [1:0]              cfg_status_q;
    logic                    rf_wr_en_q;
    logic [AW-1:0]           rf_wr_addr_q;
    logic [DATA_WIDTH-1:0]   rf_wr_data_q;
    logic [AW-1:0]           rf_rd_addr_q;

    // Outputs are computed for the state being entered, so every port value is a flop
    // and lines up with the cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_enable_q <= 1'b0;
            req_mode_q   <= '0;
            req_rate_q   <= '0;
            cfg_ready_q  <= 1'b1;
            cfg_done_q   <= 1'b0;
            cfg_status_q <= RES_OK;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= ADDR_PARK;
            rf_wr_data_q <= '0;
            rf_rd_addr_q <= ADDR_PARK;
        end else begin
            // NOTE: non-blocking defaults first, then per-state overrides; the last NBA wins,
            // which keeps the idle-port values in force without a combinational next-state block.
            cfg_done_q   <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= ADDR_PARK;
            rf_wr_data_q <= '0;
            rf_rd_addr_q <= ADDR_PARK;

            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        req_enable_q <= cfg_enable;
                        req_mode_q   <= cfg_mode;
                        req_rate_q   <= cfg_rate;
                        cfg_status_q <= RES_OK;
                        cfg_ready_q  <= 1'b0;
                        rf_wr_en_q   <= 1'b1;
                        rf_wr_addr_q <= ADDR_CTRL;
                        rf_wr_data_q <= DATA_WIDTH'({cfg_mode, 1'b0});
                        state_q      <= ST_DIS;
                    end
                end

                ST_DIS: begin
                    cnt_q        <= '0;
                    rf_rd_addr_q <= ADDR_STATUS;
                    state_q      <= ST_WAIT_IDLE;
                end

                ST_WAIT_IDLE: begin
                    if (rf_rd_valid && !rf_rd_data[0]) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_wr_addr_q <= ADDR_BAUD;
                        rf_wr_data_q <= DATA_WIDTH'(req_rate_q);
                        state_q      <= ST_WR_BAUD;
                    end else if (cnt_q == CNT_LAST) begin
                        cfg_status_q <= RES_BUSY_TO;
                        cfg_done_q   <= 1'b1;
                        state_q      <= ST_FAIL;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        rf_rd_addr_q <= ADDR_STATUS;
                    end
                end

                ST_WR_BAUD: begin
                    cnt_q        <= '0;
                    rf_rd_addr_q <= ADDR_BAUD;
                    state_q      <= ST_WAIT_COMMIT;
                end

                ST_WAIT_COMMIT: begin
                    // Success is tested before expiry, so a commit on the last poll still wins.
                    if (rf_rd_data == DATA_WIDTH'(req_rate_q)) begin
                        rf_wr_en_q   <= 1'b1;
                        rf_wr_addr_q <= ADDR_STATUS;
                        rf_wr_data_q <= DATA_WIDTH'(2);
                        state_q      <= ST_CLR_ERR;
                    end else if (cnt_q == CNT_LAST) begin
                        cfg_status_q <= RES_COMMIT_TO;
                        cfg_done_q   <= 1'b1;
                        state_q      <= ST_FAIL;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        rf_rd_addr_q <= ADDR_BAUD;
                    end
                end

                ST_CLR_ERR: begin
                    rf_wr_en_q   <= 1'b1;
                    rf_wr_addr_q <= ADDR_CTRL;
                    rf_wr_data_q <= DATA_WIDTH'({req_mode_q, req_enable_q});
                    state_q      <= ST_WR_CTRL;
                end

                ST_WR_CTRL: begin
`ifdef UART_CFG_SEQ_VERIFY_EN
                    rf_rd_addr_q <= ADDR_CTRL;
                    state_q      <= ST_VERIFY;
`else
                    cfg_done_q   <= 1'b1;
                    state_q      <= ST_DONE;
`endif
                end

`ifdef UART_CFG_SEQ_VERIFY_EN
                ST_VERIFY: begin
                    cfg_done_q <= 1'b1;
                    if (rf_rd_data[3:0] == {req_mode_q, req_enable_q}) begin
                        state_q <= ST_DONE;
                    end else begin
                        cfg_status_q <= RES_CTRL_MISMATCH;
                        state_q      <= ST_FAIL;
                    end
                end
`endif

                ST_DONE, ST_FAIL: begin
                    cfg_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    cfg_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_status = cfg_status_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_rd_addr = rf_rd_addr_q;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Directed bench for uart_cfg_sequencer against a small behavioural UART config regfile
// (CTRL, BAUD shadow/active with update_ok commit, STATUS busy + W1C sticky error).
module tb_uart_cfg_sequencer;

    localparam int TO = 64;
`ifdef UART_CFG_SEQ_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_enable;
    logic [2:0]  cfg_mode;
    logic [15:0] cfg_rate;
    logic        cfg_ready;
    logic        cfg_done;
    logic [1:0]  cfg_status;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_rd_valid;

    uart_cfg_sequencer #(
        .DATA_WIDTH    (16),
        .AW            (3),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_enable (cfg_enable),
        .cfg_mode   (cfg_mode),
        .cfg_rate   (cfg_rate),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .cfg_status (cfg_status),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_rd_valid(rf_rd_valid)
    );

    always #5 clk = ~clk;

    // Regfile model
    logic        busy, update_ok, uart_error, model_clear;
    logic [15:0] ctrl_r, shadow_r, active_r;
    logic        err_r;
    logic [2:0]  log_addr [0:15];
    logic [15:0] log_data [0:15];
    int          wr_cnt;
    int          port_viol = 0;

    always @(posedge clk) begin
        if (model_clear) begin
            ctrl_r   <= 16'h0000;
            shadow_r <= 16'h2580;
            active_r <= 16'h2580;
            err_r    <= 1'b0;
            wr_cnt   <= 0;
        end else begin
            if (uart_error) err_r <= 1'b1;
            if (update_ok) active_r <= shadow_r;
            if (rf_wr_en) begin
                if (wr_cnt < 16) begin
                    log_addr[wr_cnt] <= rf_wr_addr;
                    log_data[wr_cnt] <= rf_wr_data;
                end
                wr_cnt <= wr_cnt + 1;
                case (rf_wr_addr)
                    3'd0: ctrl_r <= rf_wr_data;
                    3'd1: begin
                        shadow_r <= rf_wr_data;
                        if (update_ok) active_r <= rf_wr_data;
                    end
                    3'd2: if (rf_wr_data[1]) err_r <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rf_rd_data  = 16'h0000;
        rf_rd_valid = 1'b0;
        case (rf_rd_addr)
            3'd0: begin rf_rd_data = ctrl_r;               rf_rd_valid = 1'b1; end
            3'd1: begin rf_rd_data = active_r;             rf_rd_valid = 1'b1; end
            3'd2: begin rf_rd_data = {14'b0, err_r, busy}; rf_rd_valid = 1'b1; end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (!rf_wr_en && (rf_wr_addr !== 3'h7 || rf_wr_data !== 16'h0000)) port_viol++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cfg(input logic en, input logic [2:0] mode, input logic [15:0] rate);
        @(negedge clk);
        cfg_start  = 1'b1;
        cfg_enable = en;
        cfg_mode   = mode;
        cfg_rate   = rate;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    // Called in the cycle after the start cycle; returns cycles from start to cfg_done.
    task automatic wait_done(output int n);
        n = 1;
        while (!cfg_done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rd(input logic [2:0] addr);
        int n = 0;
        while (rf_rd_addr !== addr && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_rd_addr", rf_rd_addr, addr);
    endtask

    task automatic clear_model();
        @(negedge clk);
        model_clear = 1'b1;
        @(negedge clk);
        model_clear = 1'b0;
    endtask

    int lat;
    int m;

    initial begin
        rst_n = 1'b1; cfg_start = 1'b0; cfg_enable = 1'b0; cfg_mode = 3'd0; cfg_rate = 16'h0;
        busy = 1'b0; update_ok = 1'b1; uart_error = 1'b0; model_clear = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready",   cfg_ready,  1);
        check("rst_done",    cfg_done,   0);
        check("rst_status",  cfg_status, 0);
        check("rst_wr_en",   rf_wr_en,   0);
        check("rst_wr_addr", rf_wr_addr, 3'h7);
        check("rst_wr_data", rf_wr_data, 0);
        check("rst_rd_addr", rf_rd_addr, 3'h7);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear = 1'b0;

        // Nominal sequence, no waits
        start_cfg(1'b1, 3'b101, 16'h1C20);
        check("t1_ready_low", cfg_ready, 0);
        wait_done(lat);
        check("t1_latency", lat, 7 + V);
        check("t1_status",  cfg_status, 0);
        check("t1_wr_cnt",  wr_cnt, 4);
        check("t1_wr0", {log_addr[0], log_data[0]}, {3'd0, 16'h000A});
        check("t1_wr1", {log_addr[1], log_data[1]}, {3'd1, 16'h1C20});
        check("t1_wr2", {log_addr[2], log_data[2]}, {3'd2, 16'h0002});
        check("t1_wr3", {log_addr[3], log_data[3]}, {3'd0, 16'h000B});
        check("t1_uart_rate", active_r, 16'h1C20);
        @(negedge clk);
        check("t1_done_pulse", cfg_done, 0);
        check("t1_ready_back", cfg_ready, 1);

        // Sticky error raised before start is cleared by the sequence
        clear_model();
        uart_error = 1'b1;
        @(negedge clk);
        uart_error = 1'b0;
        check("t2_err_before", err_r, 1);
        start_cfg(1'b1, 3'b010, 16'h0100);
        wait_done(lat);
        check("t2_err_after", err_r, 0);
        check("t2_status",    cfg_status, 0);
        check("t2_ctrl",      ctrl_r, 16'h0005);
        @(negedge clk);

        // Busy for 50 polls, plus an ignored start mid-sequence
        clear_model();
        busy = 1'b1;
        start_cfg(1'b0, 3'b011, 16'h04B0);
        wait_rd(3'd2);
        m = 0;
        while (!cfg_done && m < 200) begin
            cfg_start = (m == 10);
            if (m == 10) begin cfg_rate = 16'hFFFF; cfg_mode = 3'b111; cfg_enable = 1'b1; end
            if (m == 50) busy = 1'b0;
            @(negedge clk);
            m++;
        end
        cfg_start = 1'b0;
        check("t3_stall_len", m, 55 + V);
        check("t3_status",    cfg_status, 0);
        check("t3_rate",      active_r, 16'h04B0);
        check("t3_ctrl",      ctrl_r, 16'h0006);
        @(negedge clk);

        // Busy drops on the very last allowed poll: still a success
        clear_model();
        busy = 1'b1;
        start_cfg(1'b1, 3'b001, 16'h0300);
        wait_rd(3'd2);
        m = 0;
        while (!cfg_done && m < 200) begin
            if (m == TO - 1) busy = 1'b0;
            @(negedge clk);
            m++;
        end
        check("t4_edge_len", m, TO + 4 + V);
        check("t4_status",   cfg_status, 0);
        @(negedge clk);

        // Busy stuck: busy timeout
        clear_model();
        busy = 1'b1;
        start_cfg(1'b1, 3'b101, 16'h1C20);
        wait_rd(3'd2);
        m = 0;
        while (!cfg_done && m < 200) begin
            @(negedge clk);
            m++;
        end
        check("t5_to_len",  m, TO);
        check("t5_status",  cfg_status, 1);
        check("t5_ctrl",    ctrl_r, 16'h000A);
        check("t5_wr_cnt",  wr_cnt, 1);
        check("t5_shadow",  shadow_r, 16'h2580);
        @(negedge clk);
        check("t5_ready",   cfg_ready, 1);
        check("t5_status_held", cfg_status, 1);
        busy = 1'b0;

        // Commit never happens: commit timeout
        clear_model();
        update_ok = 1'b0;
        start_cfg(1'b1, 3'b001, 16'h1234);
        wait_rd(3'd1);
        m = 0;
        while (!cfg_done && m < 200) begin
            @(negedge clk);
            m++;
        end
        check("t6_to_len",  m, TO);
        check("t6_status",  cfg_status, 2);
        check("t6_rate",    active_r, 16'h2580);
        check("t6_shadow",  shadow_r, 16'h1234);
        check("t6_ctrl",    ctrl_r, 16'h0002);
        @(negedge clk);

        // Reset during WAIT_COMMIT
        start_cfg(1'b1, 3'b100, 16'h00AA);
        check("t7_status_cleared", cfg_status, 0);
        wait_rd(3'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_wr_en",   rf_wr_en,  0);
        check("t7_ready",   cfg_ready, 1);
        check("t7_rd_addr", rf_rd_addr, 3'h7);
        @(negedge clk);
        rst_n = 1'b1;
        update_ok = 1'b1;

        // Recovery after reset
        clear_model();
        start_cfg(1'b1, 3'b110, 16'h2222);
        wait_done(lat);
        check("t8_latency", lat, 7 + V);
        check("t8_status",  cfg_status, 0);
        check("t8_ctrl",    ctrl_r, 16'h000D);
        @(negedge clk);

        check("idle_port_rule", port_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cfg_sequencer.md
Name: uart_cfg_sequencer

Overview:
- Host-side controller that programs the UART config register file (CTRL @0, BAUD @1, STATUS @2) in a safe order.
- Order: disable UART, wait for not-busy, write BAUD shadow, wait for commit, clear sticky error, write final CTRL.
- Sits between the system config master and the regfile host write/read port. It is the sole driver of that port while active.
- Reports completion and a 2-bit result code.

Parameters:
- DATA_WIDTH, 16, regfile data width.
- AW, 3, regfile address width (clog2(N_Reg)+1 for N_Reg=4).
- TIMEOUT_CYCLES, 1024, max poll cycles per wait state; counter width clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  request pulse; accepted only when cfg_ready=1.
- cfg_enable  in  1  requested UART enable.
- cfg_mode  in  3  requested mode.
- cfg_rate  in  16  requested baud divisor.
- cfg_ready  out  1  high in IDLE.
- cfg_done  out  1  one-cycle completion pulse.
- cfg_status  out  2  result: 0 OK, 1 busy timeout, 2 commit timeout, 3 CTRL readback mismatch; held until next accept.
- rf_wr_en  out  1  regfile write enable.
- rf_wr_addr  out  AW  regfile write address.
- rf_wr_data  out  DATA_WIDTH  regfile write data.
- rf_rd_addr  out  AW  regfile read address (combinational read, same-cycle data).
- rf_rd_data  in  DATA_WIDTH  regfile read data.
- rf_rd_valid  in  1  read data valid.

Behaviour:
- Reset (async, immediate):
  - State IDLE; cfg_ready=1, cfg_done=0, cfg_status=0.
  - rf_wr_en=0, rf_wr_addr=all-ones, rf_wr_data=0, rf_rd_addr=all-ones; timeout counter 0.
- Idle-port rule: whenever rf_wr_en=0, rf_wr_addr=all-ones (out of bounds) and rf_wr_data=0. This prevents the regfile same-address write bypass from corrupting poll reads.
- Accept: cfg_start && IDLE latches enable/mode/rate into request regs, clears cfg_status, goes to DIS. cfg_start outside IDLE is ignored.
- All outputs are registered. Each write state asserts rf_wr_en for exactly 1 cycle.
- States:
  - DIS: write addr 0, data {12'b0, req_mode, 1'b0} -> WAIT_IDLE, counter=0.
  - WAIT_IDLE: rf_rd_addr=2 each cycle.
    - rf_rd_valid && rf_rd_data[0]==0 -> WR_BAUD.
    - Else counter++; counter==TIMEOUT_CYCLES-1 -> FAIL, status=1.
  - WR_BAUD: write addr 1, data req_rate -> WAIT_COMMIT, counter=0.
  - WAIT_COMMIT: rf_rd_addr=1.
    - rf_rd_data==req_rate -> CLR_ERR.
    - Else counter++; expiry -> FAIL, status=2.
  - CLR_ERR: write addr 2, data 16'h0002 (W1C error bit) -> WR_CTRL.
  - WR_CTRL: write addr 0, data {12'b0, req_mode, req_enable} -> VERIFY if macro defined, else DONE.
  - DONE: cfg_done=1 for 1 cycle -> IDLE.
  - FAIL: cfg_done=1 for 1 cycle, status held -> IDLE. CTRL is left with enable=0.
- Timeout: counter saturates, no wrap. A poll that succeeds in the same cycle as expiry counts as success.
- A uart_error occurring during the sequence before CLR_ERR is cleared. One occurring after CLR_ERR remains visible in STATUS; no sequencer reaction.
- Latency, no-wait case (busy=0, BAUD committed on the first WAIT_COMMIT cycle), macro off: accept -> cfg_done = 7 cycles.
- Reset mid-operation: immediate IDLE; the partially written regfile is not rolled back.

Optional Feature:
- Macro UART_CFG_SEQ_VERIFY_EN.
- Defined: adds state VERIFY after WR_CTRL. Reads addr 0 for one cycle.
  - rf_rd_data[3:0]=={req_mode, req_enable} -> DONE.
  - Else FAIL with status=3.
  - Latency +1 cycle.
- Undefined: VERIFY state absent, status code 3 never produced, WR_CTRL -> DONE.

Test Plan:
- Start enable=1, mode=3'b101, rate=16'h1C20; busy=0; update_ok=1 -> write sequence addr0=0x000A, addr1=0x1C20, addr2=0x0002, addr0=0x000B; cfg_done pulse; status=0; uart_rate=0x1C20.
- busy held 1 for 50 cycles, then 0 -> sequence stalls in WAIT_IDLE exactly until busy drops, then completes; status=0.
- busy stuck 1, TIMEOUT_CYCLES=16 -> cfg_done 16 cycles after entering WAIT_IDLE; status=1; CTRL enable=0; no BAUD write.
- update_ok stuck 0 -> status=2; uart_rate keeps reset value 0x2580; shadow holds new rate.
- uart_error pulsed before start -> STATUS[1]=1 before, 0 after CLR_ERR; status=0.
- rst_n asserted during WAIT_COMMIT -> same cycle rf_wr_en=0, cfg_ready=1; cfg_start during active sequence is ignored (request regs unchanged).
